// File: rtl/ddr3_test_pkg.sv
// Shared definitions for the DDR3 traffic checker: FSM state encoding,
// the LFSR polynomial mask, the default seed and the LFSR step function.
package ddr3_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam logic [31:0] LFSR_MASK    = 32'h8020_0003;
    localparam logic [31:0] DEFAULT_SEED = 32'hACE1_2468;

    // One step of the right-shifting Galois LFSR.
    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        lfsr_next = (v >> 1) ^ (v[0] ? LFSR_MASK : 32'h0);
    endfunction

endpackage

// File: rtl/ddr3_lfsr32.sv
// 32-bit Galois LFSR used both as the write-pattern generator and as the
// expected-read-data generator.
// Ports:
//   clk, reset_n  clock / async active-low reset (reset loads SEED)
//   load          reload SEED (wins over advance)
//   advance       step the LFSR by one
//   value         current LFSR word
module ddr3_lfsr32
    import ddr3_test_pkg::*;
#(
    parameter logic [31:0] SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic        advance,
    output logic [31:0] value
);

    logic [31:0] value_q;
    logic [31:0] value_d;

    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = SEED;
        end else if (advance) begin
            value_d = lfsr_next(value_q);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value_q <= SEED;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/ddr3_traffic_checker.sv
// Avalon-MM initiator that writes an LFSR pattern over a word range of the
// DDR3 controller, reads it back with pipelined reads and compares the data.
// Ports:
//   clk, reset_n            clock / async active-low reset
//   start, init_done        run request (honoured only when calibrated and idle)
//   avm_*                   Avalon-MM initiator towards the DDR3 controller
//   busy                    run in progress
//   status_mon              run finished with zero errors
//   error_mon               sticky mismatch flag
//   err_count               saturating mismatch count
//   first_err_addr          word address of the first mismatch
module ddr3_traffic_checker
    import ddr3_test_pkg::*;
#(
    parameter int unsigned ADDR_W      = 26,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned BASE_ADDR   = 0,
    parameter int unsigned NUM_WORDS   = 1024,
    parameter int unsigned MAX_PENDING = 8,
    parameter logic [31:0] SEED        = DEFAULT_SEED
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  init_done,
    output logic [ADDR_W-1:0]     avm_address,
    output logic                  avm_read,
    output logic                  avm_write,
    output logic [DATA_W-1:0]     avm_writedata,
    output logic [DATA_W/8-1:0]   avm_byteenable,
    input  logic                  avm_waitrequest,
    input  logic [DATA_W-1:0]     avm_readdata,
    input  logic                  avm_readdatavalid,
    output logic                  busy,
    output logic                  status_mon,
    output logic                  error_mon,
    output logic [15:0]           err_count,
    output logic [ADDR_W-1:0]     first_err_addr
);

    localparam int unsigned IDX_W  = $clog2(NUM_WORDS + 1);
    localparam int unsigned PEND_W = $clog2(MAX_PENDING + 1);
    localparam int unsigned LANES  = DATA_W / 32;

    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_WORDS - 1);
    localparam logic [IDX_W-1:0]  ALL_IDX  = IDX_W'(NUM_WORDS);
    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0]    rd_idx_q, rd_idx_d;
    logic [IDX_W-1:0]    cmp_idx_q, cmp_idx_d;
    logic [PEND_W-1:0]   pending_q, pending_d;
    logic [15:0]         err_count_q, err_count_d;
    logic                error_mon_q, error_mon_d;
    logic [ADDR_W-1:0]   first_err_addr_q, first_err_addr_d;

    logic [31:0]         wr_lfsr;
    logic [31:0]         exp_lfsr;
    logic                start_ok;
    logic                wr_fire;
    logic                rd_fire;
    logic                rsp_fire;
    logic                mismatch;

    assign start_ok = (state_q == ST_IDLE || state_q == ST_DONE) && start && init_done;
    assign wr_fire  = (state_q == ST_WRITE) && !avm_waitrequest;
    // pending only grows on an accepted read, so once avm_read is high it
    // stays high until the responder takes it.
    assign avm_read = (state_q == ST_READ) && (pending_q < PEND_MAX);
    assign rd_fire  = avm_read && !avm_waitrequest;
    // Responses outside READ/DRAIN (e.g. stragglers after a reset) are dropped;
    // the pending guard keeps a spurious pulse from underflowing the counter.
    assign rsp_fire = avm_readdatavalid && (state_q == ST_READ || state_q == ST_DRAIN)
                      && (pending_q != '0);
    assign mismatch = rsp_fire && (avm_readdata != {LANES{exp_lfsr}});

    ddr3_lfsr32 #(.SEED(SEED)) u_wr_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (start_ok),
        .advance (wr_fire),
        .value   (wr_lfsr)
    );

    ddr3_lfsr32 #(.SEED(SEED)) u_exp_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (start_ok),
        .advance (rsp_fire),
        .value   (exp_lfsr)
    );

    always_comb begin
        state_d          = state_q;
        wr_idx_d         = wr_idx_q;
        rd_idx_d         = rd_idx_q;
        cmp_idx_d        = cmp_idx_q;
        pending_d        = pending_q;
        err_count_d      = err_count_q;
        error_mon_d      = error_mon_q;
        first_err_addr_d = first_err_addr_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_ok) begin
                    state_d          = ST_WRITE;
                    wr_idx_d         = '0;
                    rd_idx_d         = '0;
                    cmp_idx_d        = '0;
                    pending_d        = '0;
                    err_count_d      = '0;
                    error_mon_d      = 1'b0;
                    first_err_addr_d = '0;
                end
            end
            ST_WRITE: begin
                if (wr_fire) begin
                    wr_idx_d = wr_idx_q + IDX_W'(1);
                    if (wr_idx_q == LAST_IDX) begin
                        state_d  = ST_READ;
                        rd_idx_d = '0;
                    end
                end
            end
            ST_READ: begin
                if (rd_fire) begin
                    rd_idx_d = rd_idx_q + IDX_W'(1);
                    if (rd_idx_q == LAST_IDX) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (pending_q == '0 && cmp_idx_q == ALL_IDX) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Accept and response in the same cycle cancel out.
        if (rd_fire && !rsp_fire) begin
            pending_d = pending_q + PEND_W'(1);
        end else if (!rd_fire && rsp_fire) begin
            pending_d = pending_q - PEND_W'(1);
        end

        if (rsp_fire) begin
            cmp_idx_d = cmp_idx_q + IDX_W'(1);
            if (mismatch) begin
                if (err_count_q != 16'hFFFF) begin
                    err_count_d = err_count_q + 16'd1;
                end
                error_mon_d = 1'b1;
                if (!error_mon_q) begin
                    first_err_addr_d = BASE + ADDR_W'(cmp_idx_q);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= ST_IDLE;
            wr_idx_q         <= '0;
            rd_idx_q         <= '0;
            cmp_idx_q        <= '0;
            pending_q        <= '0;
            err_count_q      <= '0;
            error_mon_q      <= 1'b0;
            first_err_addr_q <= '0;
        end else begin
            state_q          <= state_d;
            wr_idx_q         <= wr_idx_d;
            rd_idx_q         <= rd_idx_d;
            cmp_idx_q        <= cmp_idx_d;
            pending_q        <= pending_d;
            err_count_q      <= err_count_d;
            error_mon_q      <= error_mon_d;
            first_err_addr_q <= first_err_addr_d;
        end
    end

    always_comb begin
        avm_address = '0;
        if (state_q == ST_WRITE) begin
            avm_address = BASE + ADDR_W'(wr_idx_q);
        end else if (state_q == ST_READ) begin
            avm_address = BASE + ADDR_W'(rd_idx_q);
        end
    end

    assign avm_write      = (state_q == ST_WRITE);
    // Data and byte enables are qualified by the command so the bus is quiet
    // (all zero) outside a transfer, including in reset.
    assign avm_writedata  = avm_write ? {LANES{wr_lfsr}} : '0;
    assign avm_byteenable = (avm_write || avm_read) ? '1 : '0;
    assign busy           = (state_q == ST_WRITE) || (state_q == ST_READ) || (state_q == ST_DRAIN);
    assign status_mon     = (state_q == ST_DONE) && (err_count_q == 16'd0);
    assign error_mon      = error_mon_q;
    assign err_count      = err_count_q;
    assign first_err_addr = first_err_addr_q;

endmodule

// File: tb/tb_ddr3_traffic_checker.sv
// Self-checking bench: two checkers (MAX_PENDING 8 and 2) each talk to a
// behavioural Avalon responder with a word memory, configurable read latency,
// scripted/random waitrequest and per-word read-data corruption.
module tb_ddr3_traffic_checker;

    localparam int NW   = 16;
    localparam int BASE = 100;
    localparam int AW   = 26;
    localparam int QD   = 64;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    logic init_done = 1'b0;
    always #10 clk = ~clk;

    logic [1:0]    start   = '0;
    logic [1:0]    waitreq = '0;
    logic [1:0]    rdv     = '0;
    logic [1:0]    rd, wr, busy, status, errm;
    logic [AW-1:0] addr [2];
    logic [AW-1:0] ferr [2];
    logic [31:0]   wdata [2];
    logic [31:0]   rdata [2];
    logic [3:0]    be [2];
    logic [15:0]   errc [2];

    ddr3_traffic_checker #(.ADDR_W(AW), .DATA_W(32), .BASE_ADDR(BASE), .NUM_WORDS(NW),
                           .MAX_PENDING(8), .SEED(32'hACE1_2468)) dut0 (
        .clk(clk), .reset_n(reset_n), .start(start[0]), .init_done(init_done),
        .avm_address(addr[0]), .avm_read(rd[0]), .avm_write(wr[0]),
        .avm_writedata(wdata[0]), .avm_byteenable(be[0]), .avm_waitrequest(waitreq[0]),
        .avm_readdata(rdata[0]), .avm_readdatavalid(rdv[0]), .busy(busy[0]),
        .status_mon(status[0]), .error_mon(errm[0]), .err_count(errc[0]),
        .first_err_addr(ferr[0]));

    ddr3_traffic_checker #(.ADDR_W(AW), .DATA_W(32), .BASE_ADDR(BASE), .NUM_WORDS(NW),
                           .MAX_PENDING(2), .SEED(32'hACE1_2468)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start[1]), .init_done(init_done),
        .avm_address(addr[1]), .avm_read(rd[1]), .avm_write(wr[1]),
        .avm_writedata(wdata[1]), .avm_byteenable(be[1]), .avm_waitrequest(waitreq[1]),
        .avm_readdata(rdata[1]), .avm_readdatavalid(rdv[1]), .busy(busy[1]),
        .status_mon(status[1]), .error_mon(errm[1]), .err_count(errc[1]),
        .first_err_addr(ferr[1]));

    int nvec  = 0;
    int nfail = 0;
    int cyc   = 0;

    // responder configuration and bookkeeping, per checker
    int            lat [2];
    int            stall_w_idx [2], stall_w_n [2], stall_r_idx [2], stall_r_n [2];
    int            sw_cnt [2], sr_cnt [2];
    bit            rand_wait [2];
    logic [NW-1:0] corrupt [2];
    logic [31:0]   mem [2][NW];
    int            wcnt [2], rcnt [2], maxocc [2];
    logic [AW-1:0] wlog_a [2][QD];
    logic [31:0]   wlog_d [2][QD];
    logic [AW-1:0] rlog_a [2][QD];
    int            qdue [2][QD];
    logic [31:0]   qdat [2][QD];
    int            qh [2], qt [2];
    bit            prev_stall [2], prev_r [2], prev_w [2];
    logic [AW-1:0] prev_a [2];
    logic [31:0]   prev_d [2];

    // Expected pattern word n: seed stepped n times by the Galois rule.
    function automatic logic [31:0] pattern(input int n);
        logic [31:0] v = 32'hACE1_2468;
        for (int k = 0; k < n; k++) v = v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
        return v;
    endfunction

    // Number of wrong entries in the command logs of the last run.
    function automatic int log_bad(input int d);
        int b = 0;
        if (wcnt[d] != NW) b++;
        if (rcnt[d] != NW) b++;
        for (int i = 0; i < NW; i++) begin
            if (wlog_a[d][i] !== AW'(BASE + i)) b++;
            if (wlog_d[d][i] !== pattern(i)) b++;
            if (rlog_a[d][i] !== AW'(BASE + i)) b++;
        end
        return b;
    endfunction

    // Responder: drives waitrequest/readdata mid-cycle; a command seen here
    // with waitrequest low is taken at the next rising edge.
    always @(negedge clk) begin
        int idx;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (!reset_n) begin
                prev_stall[d] = 1'b0;
            end else if (prev_stall[d]) begin
                nvec++;
                if (!(rd[d] == prev_r[d] && wr[d] == prev_w[d] && addr[d] == prev_a[d] &&
                      (!wr[d] || wdata[d] == prev_d[d]))) begin
                    nfail++;
                    $display("FAIL cmd_hold dut%0d: got rd=%b wr=%b addr=%0d data=%h, required rd=%b wr=%b addr=%0d data=%h",
                             d, rd[d], wr[d], addr[d], wdata[d], prev_r[d], prev_w[d], prev_a[d], prev_d[d]);
                end
            end
            if (qh[d] != qt[d] && qdue[d][qh[d] % QD] <= cyc) begin
                rdv[d]   = 1'b1;
                rdata[d] = qdat[d][qh[d] % QD];
                qh[d]++;
            end else begin
                rdv[d]   = 1'b0;
                rdata[d] = $urandom;
            end
            waitreq[d] = 1'b0;
            if (wr[d]) begin
                if (addr[d] == AW'(BASE + stall_w_idx[d]) && sw_cnt[d] < stall_w_n[d]) begin
                    waitreq[d] = 1'b1; sw_cnt[d]++;
                end else if (rand_wait[d] && $urandom_range(0, 3) == 0) waitreq[d] = 1'b1;
            end else if (rd[d]) begin
                if (addr[d] == AW'(BASE + stall_r_idx[d]) && sr_cnt[d] < stall_r_n[d]) begin
                    waitreq[d] = 1'b1; sr_cnt[d]++;
                end else if (rand_wait[d] && $urandom_range(0, 3) == 0) waitreq[d] = 1'b1;
            end
            prev_stall[d] = reset_n && (rd[d] || wr[d]) && waitreq[d];
            prev_r[d] = rd[d]; prev_w[d] = wr[d]; prev_a[d] = addr[d]; prev_d[d] = wdata[d];
            idx = int'(addr[d]) - BASE;
            if (reset_n && wr[d] && !waitreq[d]) begin
                if (wcnt[d] < QD) begin
                    wlog_a[d][wcnt[d]] = addr[d];
                    wlog_d[d][wcnt[d]] = wdata[d];
                end
                wcnt[d]++;
                if (idx >= 0 && idx < NW) mem[d][idx] = wdata[d];
            end
            if (reset_n && rd[d] && !waitreq[d]) begin
                if (rcnt[d] < QD) rlog_a[d][rcnt[d]] = addr[d];
                rcnt[d]++;
                qdue[d][qt[d] % QD] = cyc + lat[d];
                qdat[d][qt[d] % QD] = (idx >= 0 && idx < NW) ?
                                      (mem[d][idx] ^ {31'b0, corrupt[d][idx]}) : 32'hDEAD_BEEF;
                qt[d]++;
            end
            if (qt[d] - qh[d] > maxocc[d]) maxocc[d] = qt[d] - qh[d];
        end
    end

    task automatic configure(input int d, input int l, input bit rw, input logic [NW-1:0] cm);
        lat[d] = l; rand_wait[d] = rw; corrupt[d] = cm;
        stall_w_n[d] = 0; stall_r_n[d] = 0; stall_w_idx[d] = 0; stall_r_idx[d] = 0;
    endtask

    // Pulse start and wait (bounded) for busy to fall. With restart set, a
    // second start is pulsed once the checker is reading.
    task automatic do_run(input int d, input bit restart, output bit done);
        bit pulsed = 1'b0;
        wcnt[d] = 0; rcnt[d] = 0; maxocc[d] = 0; sw_cnt[d] = 0; sr_cnt[d] = 0;
        @(posedge clk); #1 start[d] = 1'b1;
        @(posedge clk); #1 start[d] = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #1;
            if (!busy[d]) begin done = 1'b1; break; end
            if (restart && !pulsed && rd[d]) begin
                pulsed = 1'b1;
                start[d] = 1'b1;
                @(posedge clk); #1 start[d] = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            nvec++;
            if ({busy[d], status[d], errm[d], rd[d], wr[d], addr[d], wdata[d], be[d], errc[d], ferr[d]} !== '0) begin
                nfail++;
                $display("FAIL reset_outputs dut%0d: got busy=%b st=%b em=%b rd=%b wr=%b a=%h d=%h be=%h ec=%h fa=%h, required all 0",
                         d, busy[d], status[d], errm[d], rd[d], wr[d], addr[d], wdata[d], be[d], errc[d], ferr[d]);
            end
        end
        reset_n = 1'b1;
        init_done = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_ideal();
        bit done;
        int b;
        configure(0, 2, 1'b0, '0);
        do_run(0, 1'b0, done);
        b = log_bad(0);
        nvec++;
        if (!done) begin nfail++; $display("FAIL ideal_timeout: busy still %b, required 0", busy[0]); end
        nvec++;
        if (b !== 0) begin nfail++; $display("FAIL ideal_log: %0d bad entries, required 0", b); end
        nvec++;
        if (wlog_d[0][0] !== 32'hACE1_2468) begin nfail++; $display("FAIL ideal_first_data: got %h, required ace12468", wlog_d[0][0]); end
        nvec++;
        if ({status[0], errm[0], errc[0], ferr[0]} !== {1'b1, 1'b0, 16'd0, AW'(0)}) begin
            nfail++;
            $display("FAIL ideal_status: got st=%b em=%b ec=%0d fa=%0d, required st=1 em=0 ec=0 fa=0", status[0], errm[0], errc[0], ferr[0]);
        end
    endtask

    task automatic test_waitstall();
        bit done;
        int b;
        configure(0, 2, 1'b0, '0);
        stall_w_idx[0] = 5; stall_w_n[0] = 3; stall_r_idx[0] = 9; stall_r_n[0] = 2;
        do_run(0, 1'b0, done);
        b = log_bad(0);
        nvec++;
        if (!done || b !== 0) begin nfail++; $display("FAIL stall_log: done=%b bad=%0d, required done=1 bad=0", done, b); end
        nvec++;
        if (status[0] !== 1'b1 || errc[0] !== 16'd0) begin
            nfail++; $display("FAIL stall_status: got st=%b ec=%0d, required st=1 ec=0", status[0], errc[0]);
        end
    endtask

    task automatic test_corrupt();
        bit done;
        configure(0, 2, 1'b0, NW'((1 << 3) | (1 << 7)));
        do_run(0, 1'b0, done);
        nvec++;
        if (!done) begin nfail++; $display("FAIL corrupt_timeout: busy still %b, required 0", busy[0]); end
        nvec++;
        if (errc[0] !== 16'd2) begin nfail++; $display("FAIL corrupt_count: got %0d, required 2", errc[0]); end
        nvec++;
        if (ferr[0] !== AW'(BASE + 3)) begin nfail++; $display("FAIL corrupt_first: got %0d, required %0d", ferr[0], BASE + 3); end
        nvec++;
        if (errm[0] !== 1'b1 || status[0] !== 1'b0) begin
            nfail++; $display("FAIL corrupt_flags: got em=%b st=%b, required em=1 st=0", errm[0], status[0]);
        end
    endtask

    task automatic test_pending();
        bit done;
        int b;
        configure(1, 10, 1'b0, '0);
        do_run(1, 1'b0, done);
        b = log_bad(1);
        nvec++;
        if (!done || b !== 0) begin nfail++; $display("FAIL pend_log: done=%b bad=%0d, required done=1 bad=0", done, b); end
        nvec++;
        if (maxocc[1] !== 2) begin nfail++; $display("FAIL pend_max: got peak %0d outstanding, required 2", maxocc[1]); end
        nvec++;
        if (status[1] !== 1'b1 || errc[1] !== 16'd0) begin
            nfail++; $display("FAIL pend_status: got st=%b ec=%0d, required st=1 ec=0", status[1], errc[1]);
        end
    endtask

    task automatic test_start_gating();
        bit done;
        int b;
        configure(0, 3, 1'b0, '0);
        init_done = 1'b0;
        wcnt[0] = 0;
        @(posedge clk); #1 start[0] = 1'b1;
        @(posedge clk); #1 start[0] = 1'b0;
        repeat (5) @(negedge clk);
        nvec++;
        if (busy[0] !== 1'b0 || wcnt[0] !== 0) begin
            nfail++; $display("FAIL gate_init: got busy=%b writes=%0d, required busy=0 writes=0", busy[0], wcnt[0]);
        end
        init_done = 1'b1;
        do_run(0, 1'b1, done);
        b = log_bad(0);
        nvec++;
        if (!done || b !== 0) begin nfail++; $display("FAIL gate_busy_start: done=%b bad=%0d, required done=1 bad=0", done, b); end
        nvec++;
        if (status[0] !== 1'b1) begin nfail++; $display("FAIL gate_status: got %b, required 1", status[0]); end
    endtask

    task automatic test_random();
        bit done;
        int b, ne, first, d;
        for (int it = 0; it < 8; it++) begin
            d = it % 2;
            configure(d, int'($urandom_range(1, 6)), 1'b1, NW'($urandom));
            if (it >= 6) corrupt[d] = '0;
            ne = 0; first = -1;
            for (int i = 0; i < NW; i++) if (corrupt[d][i]) begin ne++; if (first < 0) first = i; end
            do_run(d, 1'b0, done);
            b = log_bad(d);
            nvec++;
            if (!done || b !== 0) begin nfail++; $display("FAIL rand_log it%0d: done=%b bad=%0d, required done=1 bad=0", it, done, b); end
            nvec++;
            if (errc[d] !== 16'(ne) || errm[d] !== (ne != 0) || status[d] !== (ne == 0)) begin
                nfail++;
                $display("FAIL rand_status it%0d: got ec=%0d em=%b st=%b, required ec=%0d em=%b st=%b",
                         it, errc[d], errm[d], status[d], ne, ne != 0, ne == 0);
            end
            nvec++;
            if (ferr[d] !== ((ne != 0) ? AW'(BASE + first) : AW'(0))) begin
                nfail++; $display("FAIL rand_first it%0d: got %0d, required %0d", it, ferr[d], (ne != 0) ? BASE + first : 0);
            end
            nvec++;
            if (maxocc[d] > ((d == 0) ? 8 : 2)) begin
                nfail++; $display("FAIL rand_pending it%0d: got peak %0d, required <= %0d", it, maxocc[d], (d == 0) ? 8 : 2);
            end
        end
    endtask

    task automatic test_reset_midrun();
        bit done, hit;
        int b;
        configure(0, 10, 1'b0, '1);
        wcnt[0] = 0; rcnt[0] = 0;
        @(posedge clk); #1 start[0] = 1'b1;
        @(posedge clk); #1 start[0] = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk); #2;
            if (rd[0] && qt[0] - qh[0] == 4) begin hit = 1'b1; break; end
        end
        @(posedge clk); #1 reset_n = 1'b0;
        #2;
        nvec++;
        if (!hit) begin nfail++; $display("FAIL midrun_reach: 4 pending not seen, required seen"); end
        nvec++;
        if ({busy[0], status[0], errm[0], rd[0], wr[0], addr[0], wdata[0], be[0], errc[0], ferr[0]} !== '0) begin
            nfail++;
            $display("FAIL midrun_reset_outputs: got busy=%b rd=%b addr=%h ec=%0d, required all 0", busy[0], rd[0], addr[0], errc[0]);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 100 && qh[0] != qt[0]; i++) @(negedge clk);
        @(negedge clk); #1;
        nvec++;
        if (qh[0] != qt[0] || errc[0] !== 16'd0 || errm[0] !== 1'b0 || busy[0] !== 1'b0) begin
            nfail++;
            $display("FAIL midrun_late_rsp: got ec=%0d em=%b busy=%b left=%0d, required ec=0 em=0 busy=0 left=0",
                     errc[0], errm[0], busy[0], qt[0] - qh[0]);
        end
        configure(0, 2, 1'b0, '0);
        do_run(0, 1'b0, done);
        b = log_bad(0);
        nvec++;
        if (!done || b !== 0 || status[0] !== 1'b1 || errc[0] !== 16'd0) begin
            nfail++;
            $display("FAIL midrun_rerun: done=%b bad=%0d st=%b ec=%0d, required done=1 bad=0 st=1 ec=0", done, b, status[0], errc[0]);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            qh[d] = 0; qt[d] = 0; wcnt[d] = 0; rcnt[d] = 0; maxocc[d] = 0;
            sw_cnt[d] = 0; sr_cnt[d] = 0; prev_stall[d] = 1'b0;
            configure(d, 2, 1'b0, '0);
        end
        test_reset();
        test_ideal();
        test_waitstall();
        test_corrupt();
        test_pending();
        test_start_gating();
        test_random();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
